// File: rtl/map_tile_fetch.sv
// map_tile_fetch: converts a tile coordinate plus map number into a map RAM word address.
// It then reads the word and returns the 3-bit block code of that tile.
// A one-word cache lets horizontally adjacent tiles that share a word skip the RAM read.
module map_tile_fetch #(
    parameter int unsigned TILES_X   = 40,
    parameter int unsigned TILES_Y   = 30,
    parameter int unsigned MAP_WORDS = 256,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic        Clk,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_tile_x,
    input  logic [4:0]  req_tile_y,
    input  logic [3:0]  map_sel,
    input  logic        invalidate,
    output logic [11:0] VGA_ADDR,
    input  logic [31:0] onchipq,
    output logic        rsp_valid,
    output logic [2:0]  blockcode,
    output logic        rsp_hit
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic [11:0] r_addr;
    logic [1:0]  r_cnt;
    logic [2:0]  r_nib;
    logic        r_cache_valid;
    logic [11:0] r_cache_tag;
    logic [31:0] r_cache_data;
    logic [2:0]  r_blockcode;
    logic        r_rsp_hit;

    logic [10:0] w_idx;
    logic [11:0] w_word;
    logic [2:0]  w_nib;
    logic        w_oor;
    logic        w_hit;
    logic        w_accept;
    logic        w_cnt_zero;
    logic [2:0]  w_cache_code;
    logic [2:0]  w_ram_code;

    // Tile index inside the map, then word address and nibble within the word.
    assign w_idx  = 11'(req_tile_y) * 11'(TILES_X) + 11'(req_tile_x);
    assign w_word = 12'(map_sel) * 12'(MAP_WORDS) + 12'(w_idx[10:3]);
    assign w_nib  = w_idx[2:0];

    assign w_oor      = ({26'd0, req_tile_x} >= TILES_X) || ({27'd0, req_tile_y} >= TILES_Y);
    // Hit check uses the cache contents before any same-edge invalidate.
    assign w_hit      = r_cache_valid && (r_cache_tag == w_word);
    assign w_accept   = req_valid && (r_state == StIdle);
    assign w_cnt_zero = (r_cnt == 2'd0);

    // Bit nib*4+3 of each nibble is spare; only the low three bits are the code.
    assign w_cache_code = r_cache_data[{w_nib, 2'b00} +: 3];
    assign w_ram_code   = onchipq[{r_nib, 2'b00} +: 3];

    assign req_ready = (r_state == StIdle);
    assign rsp_valid = (r_state == StResp);
    assign VGA_ADDR  = r_addr;
    assign blockcode = r_blockcode;
    assign rsp_hit   = r_rsp_hit;

    // State register.
    always_ff @(posedge Clk) begin
        if (RESET) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = (w_oor || w_hit) ? StResp : StWait;
                end
            end
            StWait: begin
                if (w_cnt_zero) begin
                    w_state_next = StResp;
                end
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Address, read counter, cache and response registers.
    always_ff @(posedge Clk) begin
        if (RESET) begin
            r_addr        <= 12'd0;
            r_cnt         <= 2'd0;
            r_nib         <= 3'd0;
            r_cache_valid <= 1'b0;
            r_cache_tag   <= 12'd0;
            r_cache_data  <= 32'd0;
            r_blockcode   <= 3'd0;
            r_rsp_hit     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        if (w_oor) begin
                            r_blockcode <= 3'd0;
                            r_rsp_hit   <= 1'b1;
                        end else if (w_hit) begin
                            r_blockcode <= w_cache_code;
                            r_rsp_hit   <= 1'b1;
                        end else begin
                            r_addr <= w_word;
                            r_cnt  <= 2'(RD_LAT);
                            r_nib  <= w_nib;
                        end
                    end
                end
                StWait: begin
                    if (w_cnt_zero) begin
                        r_cache_data  <= onchipq;
                        r_cache_tag   <= r_addr;
                        r_cache_valid <= 1'b1;
                        r_blockcode   <= w_ram_code;
                        r_rsp_hit     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
            // Invalidate overrides a same-edge fill.
            if (invalidate) begin
                r_cache_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_map_tile_fetch.sv
// Directed bench for map_tile_fetch with a pipelined RAM model of configurable latency.
module tb_map_tile_fetch;

    localparam int unsigned LAT = 2;

    logic        Clk = 1'b0;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_tile_x;
    logic [4:0]  req_tile_y;
    logic [3:0]  map_sel;
    logic        invalidate;
    logic [11:0] VGA_ADDR;
    logic [31:0] onchipq;
    logic        rsp_valid;
    logic [2:0]  blockcode;
    logic        rsp_hit;

    int total = 0;
    int bad   = 0;
    int lat;

    logic [31:0] q_pipe [LAT];

    map_tile_fetch #(
        .TILES_X  (40),
        .TILES_Y  (30),
        .MAP_WORDS(256),
        .RD_LAT   (LAT)
    ) dut (
        .Clk       (Clk),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tile_x(req_tile_x),
        .req_tile_y(req_tile_y),
        .map_sel   (map_sel),
        .invalidate(invalidate),
        .VGA_ADDR  (VGA_ADDR),
        .onchipq   (onchipq),
        .rsp_valid (rsp_valid),
        .blockcode (blockcode),
        .rsp_hit   (rsp_hit)
    );

    always #5 Clk = ~Clk;

    // Map RAM contents at the addresses the test touches.
    function automatic logic [31:0] mem(input logic [11:0] a);
        case (a)
            12'h10A: mem = 32'h0007_5000;
            12'h20A: mem = 32'h0003_0000;
            12'hF95: mem = 32'h5000_0000;
            default: mem = 32'h1234_5678;
        endcase
    endfunction

    // RAM samples the address on an edge and presents data LAT edges later.
    always @(posedge Clk) begin
        q_pipe[0] <= mem(VGA_ADDR);
        for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign onchipq = q_pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request and return just after its accept edge.
    task automatic start_req(input logic [5:0] x, input logic [4:0] y, input logic [3:0] m,
                             input logic inv);
        int n = 0;
        @(negedge Clk);
        while (!req_ready && n < 10) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 10) chk("ready_timeout", 32'(req_ready), 32'd1);
        req_tile_x = x;
        req_tile_y = y;
        map_sel    = m;
        req_valid  = 1'b1;
        invalidate = inv;
        @(posedge Clk);
        #1;
        req_valid  = 1'b0;
        invalidate = 1'b0;
    endtask

    // Cycles from the accept edge until rsp_valid, bounded.
    task automatic wait_rsp(output int l);
        l = 1;
        while (!rsp_valid && l < 20) begin
            @(posedge Clk);
            #1;
            l++;
        end
    endtask

    initial begin
        RESET      = 1'b1;
        req_valid  = 1'b0;
        req_tile_x = '0;
        req_tile_y = '0;
        map_sel    = '0;
        invalidate = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_blockcode", 32'(blockcode), 32'd0);
        chk("rst_rsp_hit", 32'(rsp_hit), 32'd0);
        chk("rst_addr", 32'(VGA_ADDR), 32'h000);
        RESET = 1'b0;

        // Cold miss.
        start_req(6'd3, 5'd2, 4'd1, 1'b0);
        chk("cold_addr_early", 32'(VGA_ADDR), 32'h10A);
        wait_rsp(lat);
        chk("cold_lat", 32'(lat), 32'(LAT + 2));
        chk("cold_addr", 32'(VGA_ADDR), 32'h10A);
        chk("cold_code", 32'(blockcode), 32'd5);
        chk("cold_hit", 32'(rsp_hit), 32'd0);
        @(posedge Clk);
        #1;
        chk("cold_pulse_end", 32'(rsp_valid), 32'd0);
        chk("cold_code_hold", 32'(blockcode), 32'd5);

        // Cache hit on the neighbouring tile.
        start_req(6'd4, 5'd2, 4'd1, 1'b0);
        wait_rsp(lat);
        chk("hit_lat", 32'(lat), 32'd1);
        chk("hit_code", 32'(blockcode), 32'd7);
        chk("hit_hit", 32'(rsp_hit), 32'd1);
        chk("hit_addr", 32'(VGA_ADDR), 32'h10A);

        // Same word index, different map.
        start_req(6'd4, 5'd2, 4'd2, 1'b0);
        wait_rsp(lat);
        chk("map2_lat", 32'(lat), 32'(LAT + 2));
        chk("map2_addr", 32'(VGA_ADDR), 32'h20A);
        chk("map2_code", 32'(blockcode), 32'd3);
        chk("map2_hit", 32'(rsp_hit), 32'd0);

        // Out of range in x and in y.
        start_req(6'd40, 5'd0, 4'd2, 1'b0);
        wait_rsp(lat);
        chk("oorx_lat", 32'(lat), 32'd1);
        chk("oorx_code", 32'(blockcode), 32'd0);
        chk("oorx_hit", 32'(rsp_hit), 32'd1);
        chk("oorx_addr", 32'(VGA_ADDR), 32'h20A);
        start_req(6'd0, 5'd30, 4'd2, 1'b0);
        wait_rsp(lat);
        chk("oory_lat", 32'(lat), 32'd1);
        chk("oory_code", 32'(blockcode), 32'd0);
        chk("oory_hit", 32'(rsp_hit), 32'd1);
        chk("oory_addr", 32'(VGA_ADDR), 32'h20A);

        // Cache left intact by out-of-range requests.
        start_req(6'd4, 5'd2, 4'd2, 1'b0);
        wait_rsp(lat);
        chk("rehit_lat", 32'(lat), 32'd1);
        chk("rehit_code", 32'(blockcode), 32'd3);
        chk("rehit_hit", 32'(rsp_hit), 32'd1);

        // Largest address.
        start_req(6'd39, 5'd29, 4'd15, 1'b0);
        wait_rsp(lat);
        chk("max_lat", 32'(lat), 32'(LAT + 2));
        chk("max_addr", 32'(VGA_ADDR), 32'hF95);
        chk("max_code", 32'(blockcode), 32'd5);

        // Invalidate on the capture edge: response delivered, cache stays empty.
        start_req(6'd3, 5'd2, 4'd1, 1'b0);
        repeat (LAT) @(posedge Clk);
        #1;
        invalidate = 1'b1;
        @(posedge Clk);
        #1;
        invalidate = 1'b0;
        chk("invcap_valid", 32'(rsp_valid), 32'd1);
        chk("invcap_code", 32'(blockcode), 32'd5);
        chk("invcap_hit", 32'(rsp_hit), 32'd0);
        start_req(6'd3, 5'd2, 4'd1, 1'b0);
        wait_rsp(lat);
        chk("invcap_remiss_lat", 32'(lat), 32'(LAT + 2));
        chk("invcap_remiss_hit", 32'(rsp_hit), 32'd0);

        // Invalidate at accept: this request still hits, the next one misses.
        start_req(6'd4, 5'd2, 4'd1, 1'b1);
        wait_rsp(lat);
        chk("invacc_lat", 32'(lat), 32'd1);
        chk("invacc_code", 32'(blockcode), 32'd7);
        chk("invacc_hit", 32'(rsp_hit), 32'd1);
        start_req(6'd4, 5'd2, 4'd1, 1'b0);
        wait_rsp(lat);
        chk("invacc_next_lat", 32'(lat), 32'(LAT + 2));
        chk("invacc_next_hit", 32'(rsp_hit), 32'd0);
        chk("invacc_next_code", 32'(blockcode), 32'd7);

        // Reset while waiting on the RAM.
        start_req(6'd3, 5'd2, 4'd2, 1'b0);
        RESET = 1'b1;
        @(posedge Clk);
        #1;
        RESET = 1'b0;
        chk("rstw_ready", 32'(req_ready), 32'd1);
        chk("rstw_rsp0", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge Clk);
            #1;
            chk("rstw_no_rsp", 32'(rsp_valid), 32'd0);
        end
        start_req(6'd4, 5'd2, 4'd1, 1'b0);
        wait_rsp(lat);
        chk("rstw_next_lat", 32'(lat), 32'(LAT + 2));
        chk("rstw_next_hit", 32'(rsp_hit), 32'd0);
        chk("rstw_next_code", 32'(blockcode), 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
